xgmii_frame_injector: RTL and testbench

//  Synthesizable successor to the simulation-only XGMII frame writer: takes AXI-Stream frames
//  (FCS already included) and emits XGMII TX words with start, preamble/SFD, terminate and

---
 rtl/xgmii_pkg.sv | 31 +++
 rtl/xgmii_frame_injector_term_encode.sv | 33 +++
 rtl/xgmii_frame_injector.sv | 207 ++++++++++++++++++++
 tb/tb_xgmii_frame_injector.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, TX framer state encoding and preamble helper.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_TERM,
        ST_DROP,
        ST_IFG
    } state_t;

    // Character at byte position pos of the start/preamble/SFD sequence.
    function automatic logic [7:0] pre_char(input int unsigned pos, input int unsigned pre_bytes);
        if (pos == 0) begin
            return XGMII_START;
        end
        if (pos == pre_bytes - 1) begin
            return XGMII_SFD;
        end
        return XGMII_PRE;
    endfunction

endpackage

// File: rtl/xgmii_frame_injector_term_encode.sv
// Packs a data word with k valid lanes into XGMII: lanes<k data, lane k /T/, lanes>k idle.
module xgmii_term_encode
    import xgmii_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = $clog2(DATA_W / 8 + 1)
) (
    input  logic [DATA_W-1:0]   tdata,
    input  logic [KEEP_W-1:0]   k,
    output logic [DATA_W-1:0]   txd_c,
    output logic [DATA_W/8-1:0] txc_c
);

    localparam int unsigned BYTES = DATA_W / 8;

    always_comb begin
        txd_c = '0;
        txc_c = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (i < 32'(k)) begin
                txd_c[8*i +: 8] = tdata[8*i +: 8];
                txc_c[i]        = 1'b0;
            end else if (i == 32'(k)) begin
                txd_c[8*i +: 8] = XGMII_TERM;
                txc_c[i]        = 1'b1;
            end else begin
                txd_c[8*i +: 8] = XGMII_IDLE;
                txc_c[i]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_frame_injector.sv
// AXI-Stream to XGMII TX framer: start/preamble/SFD, terminate packing, enforced IFG,
// underrun abort with /E/, and frame/abort counters. All outputs registered.
module xgmii_frame_injector
    import xgmii_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PRE_BYTES = 8,
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic [DATA_W-1:0]   xgmii_txd,
    output logic [DATA_W/8-1:0] xgmii_txc,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    abort_cnt,
    output logic                busy
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned PRE_WORDS = PRE_BYTES / BYTES;
    localparam int unsigned PW        = (PRE_WORDS > 1) ? $clog2(PRE_WORDS) : 1;
    localparam int unsigned KW        = $clog2(BYTES + 1);
    localparam int unsigned IW        = $clog2(IFG_BYTES + 2 * BYTES + 1);

    localparam logic [DATA_W-1:0] IDLE_WORD = {BYTES{XGMII_IDLE}};
    localparam logic [DATA_W-1:0] ERR_WORD  = {BYTES{XGMII_ERR}};
    localparam logic [DATA_W-1:0] TERM_WORD = {{(BYTES - 1){XGMII_IDLE}}, XGMII_TERM};

    state_t              state_q, state_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       ifg_q, ifg_d;
    logic [DATA_W-1:0]   txd_q, txd_d;
    logic [BYTES-1:0]    txc_q, txc_d;
    logic                tready_q, tready_d;
    logic [CNT_W-1:0]    frame_q, frame_d;
    logic [CNT_W-1:0]    abort_q, abort_d;
    logic                busy_q, busy_d;

    logic [KW-1:0]       keep_k;
    logic                keep_run;
    logic [KW-1:0]       enc_k;
    logic [DATA_W-1:0]   enc_txd;
    logic [BYTES-1:0]    enc_txc;
    logic [DATA_W-1:0]   pre_txd;
    logic [BYTES-1:0]    pre_txc;
    logic                pre_last;
    logic [IW-1:0]       ifg_sum;
    logic                ifg_done;
    logic [IW-1:0]       ifg_sat;

    // Valid byte count on the last beat: contiguous ones from lane 0, stray upper bits ignored.
    always_comb begin
        keep_k   = '0;
        keep_run = 1'b1;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (keep_run && s_tkeep[i]) begin
                keep_k = KW'(i + 1);
            end else begin
                keep_run = 1'b0;
            end
        end
    end

    assign enc_k = s_tlast ? keep_k : KW'(BYTES);

    xgmii_term_encode #(
        .DATA_W (DATA_W),
        .KEEP_W (KW)
    ) u_term_encode (
        .tdata  (s_tdata),
        .k      (enc_k),
        .txd_c  (enc_txd),
        .txc_c  (enc_txc)
    );

    always_comb begin
        pre_txd = '0;
        pre_txc = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            pre_txd[8*i +: 8] = pre_char(32'(pre_q) * BYTES + i, PRE_BYTES);
            pre_txc[i]        = (pre_q == '0) && (i == 0);
        end
    end

    assign pre_last = (pre_q == PW'(PRE_WORDS - 1));
    assign ifg_sum  = ifg_q + IW'(BYTES);
    assign ifg_done = (ifg_sum >= IW'(IFG_BYTES));
    assign ifg_sat  = ifg_done ? IW'(IFG_BYTES) : ifg_sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s_tvalid) state_d = ST_PRE;
            ST_PRE:  if (pre_last) state_d = ST_DATA;
            ST_DATA: begin
                if (!s_tvalid) begin
                    state_d = ST_DROP;
                end else if (s_tlast) begin
                    state_d = (keep_k == KW'(BYTES)) ? ST_TERM : ST_IFG;
                end
            end
            ST_TERM: state_d = ST_IFG;
            ST_DROP: if (s_tvalid && s_tlast) state_d = ST_IFG;
            ST_IFG:  if (ifg_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; ifg_q counts idle bytes since /T/ or /E/.
    always_comb begin
        txd_d    = IDLE_WORD;
        txc_d    = '1;
        tready_d = 1'b0;
        frame_d  = frame_q;
        abort_d  = abort_q;
        ifg_d    = ifg_q;
        pre_d    = '0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_PRE: begin
                txd_d = pre_txd;
                txc_d = pre_txc;
                if (pre_last) begin
                    tready_d = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            ST_DATA: begin
                if (!s_tvalid) begin
                    txd_d    = ERR_WORD;
                    abort_d  = abort_q + CNT_W'(1);
                    tready_d = 1'b1;
                    ifg_d    = IW'(BYTES);
                end else begin
                    txd_d = enc_txd;
                    txc_d = enc_txc;
                    if (!s_tlast) begin
                        tready_d = 1'b1;
                    end else if (keep_k != KW'(BYTES)) begin
                        frame_d = frame_q + CNT_W'(1);
                        ifg_d   = IW'(BYTES) - IW'(keep_k);
                    end
                end
            end
            ST_TERM: begin
                txd_d   = TERM_WORD;
                frame_d = frame_q + CNT_W'(1);
                ifg_d   = IW'(BYTES);
            end
            ST_DROP: begin
                tready_d = !(s_tvalid && s_tlast);
                ifg_d    = ifg_sat;
            end
            ST_IFG: begin
                ifg_d = ifg_sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            ifg_q    <= '0;
            txd_q    <= IDLE_WORD;
            txc_q    <= '1;
            tready_q <= 1'b0;
            frame_q  <= '0;
            abort_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            ifg_q    <= ifg_d;
            txd_q    <= txd_d;
            txc_q    <= txc_d;
            tready_q <= tready_d;
            frame_q  <= frame_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
        end
    end

    assign s_tready  = tready_q;
    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign frame_cnt = frame_q;
    assign abort_cnt = abort_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xgmii_frame_injector.sv
// Bench for xgmii_frame_injector: 64-bit and 32-bit instances, directed table plus
// randomized frames checked by an XGMII byte-stream parser.
module tb_xgmii_frame_injector;
    import xgmii_pkg::*;

    localparam int IFG = 12;
    localparam int PRE = 8;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst;

    logic [63:0]   a_tdata;
    logic [7:0]    a_tkeep;
    logic          a_tvalid, a_tlast, a_tready, a_busy;
    logic [63:0]   a_txd;
    logic [7:0]    a_txc;
    logic [CW-1:0] a_fcnt, a_acnt;

    logic [31:0]   b_tdata;
    logic [3:0]    b_tkeep;
    logic          b_tvalid, b_tlast, b_tready, b_busy;
    logic [31:0]   b_txd;
    logic [3:0]    b_txc;
    logic [CW-1:0] b_fcnt, b_acnt;

    always #5 clk = ~clk;

    xgmii_frame_injector #(.DATA_W(64), .PRE_BYTES(PRE), .IFG_BYTES(IFG), .CNT_W(CW)) u64 (
        .clk(clk), .rst(rst), .s_tdata(a_tdata), .s_tkeep(a_tkeep), .s_tvalid(a_tvalid),
        .s_tready(a_tready), .s_tlast(a_tlast), .xgmii_txd(a_txd), .xgmii_txc(a_txc),
        .frame_cnt(a_fcnt), .abort_cnt(a_acnt), .busy(a_busy));

    xgmii_frame_injector #(.DATA_W(32), .PRE_BYTES(PRE), .IFG_BYTES(IFG), .CNT_W(CW)) u32 (
        .clk(clk), .rst(rst), .s_tdata(b_tdata), .s_tkeep(b_tkeep), .s_tvalid(b_tvalid),
        .s_tready(b_tready), .s_tlast(b_tlast), .xgmii_txd(b_txd), .xgmii_txc(b_txc),
        .frame_cnt(b_fcnt), .abort_cnt(b_acnt), .busy(b_busy));

    // Captured output words and the frames the bench expects to see
    logic [63:0] aw_d[$];
    logic [7:0]  aw_c[$];
    logic [31:0] bw_d[$];
    logic [3:0]  bw_c[$];
    logic [7:0]  ea[$], eb[$];
    int          ea_len[$], eb_len[$];

    always @(negedge clk) begin
        aw_d.push_back(a_txd);
        aw_c.push_back(a_txc);
        bw_d.push_back(b_txd);
        bw_c.push_back(b_txc);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        aw_d.delete(); aw_c.delete(); bw_d.delete(); bw_c.delete();
        ea.delete(); eb.delete(); ea_len.delete(); eb_len.delete();
    endtask

    // Sends one frame; gap_at>=0 drops tvalid for gap_cyc cycles before that beat.
    task automatic send(input bit w32, input int len, input bit empty_last, input bit stray,
                        input bit rnd, input int gap_at, input int gap_cyc, input bit record);
        logic [7:0] fb[$];
        int B, nb, k, to;
        bit acc, last;
        logic [63:0] d;
        logic [7:0] kp;
        B = w32 ? 4 : 8;
        for (int i = 0; i < len; i++) begin
            fb.push_back(rnd ? 8'($urandom) : 8'(i));
            if (record) begin
                if (w32) eb.push_back(fb[i]); else ea.push_back(fb[i]);
            end
        end
        if (record) begin
            if (w32) eb_len.push_back(len); else ea_len.push_back(len);
        end
        nb = (len + B - 1) / B + (empty_last ? 1 : 0);
        for (int b = 0; b < nb; b++) begin
            d = '0;
            kp = '0;
            for (int l = 0; l < B; l++) begin
                if (b * B + l < len) begin
                    d[8*l +: 8] = fb[b * B + l];
                    kp[l] = 1'b1;
                end
            end
            last = (b == nb - 1);
            k = len - b * B;
            if (k < 0) k = 0;
            if (last && stray && k + 1 < B) kp[k + 1] = 1'b1;
            if (gap_at == b) begin
                if (w32) b_tvalid = 1'b0; else a_tvalid = 1'b0;
                repeat (gap_cyc) tick();
            end
            if (w32) begin
                b_tdata = d[31:0]; b_tkeep = kp[3:0]; b_tlast = last; b_tvalid = 1'b1;
            end else begin
                a_tdata = d; a_tkeep = kp; a_tlast = last; a_tvalid = 1'b1;
            end
            acc = 1'b0;
            to = 0;
            while (!acc && to < 200) begin
                @(negedge clk);
                acc = w32 ? b_tready : a_tready;
                tick();
                to++;
            end
            if (!acc) begin
                chk(1'b0, "accept_timeout", 64'(b), 64'(nb));
                break;
            end
        end
        if (w32) begin b_tvalid = 1'b0; b_tlast = 1'b0; end
        else begin a_tvalid = 1'b0; a_tlast = 1'b0; end
    endtask

    task automatic wait_idle(input bit w32);
        int quiet, to;
        quiet = 0;
        to = 0;
        while (quiet < 3 && to < 400) begin
            @(negedge clk);
            if (w32 ? b_busy : a_busy) quiet = 0; else quiet++;
            to++;
        end
        if (quiet < 3) chk(1'b0, "idle_timeout", 64'(to), 64'(400));
        tick();
    endtask

    // Parses the captured byte stream as XGMII frames and compares against expected frames.
    task automatic parse_check(input bit w32);
        logic [7:0] sb[$];
        bit sc[$];
        logic [7:0] ex[$];
        int el[$];
        int B, p, off, idle, bad;
        bit ok;
        logic [7:0] want;
        B = w32 ? 4 : 8;
        if (w32) begin
            foreach (bw_d[i]) for (int l = 0; l < 4; l++) begin
                sb.push_back(bw_d[i][8*l +: 8]); sc.push_back(bw_c[i][l]);
            end
            ex = eb; el = eb_len;
        end else begin
            foreach (aw_d[i]) for (int l = 0; l < 8; l++) begin
                sb.push_back(aw_d[i][8*l +: 8]); sc.push_back(aw_c[i][l]);
            end
            ex = ea; el = ea_len;
        end
        p = 0;
        off = 0;
        foreach (el[f]) begin
            idle = 0;
            while (p < sb.size() && sc[p] && sb[p] == XGMII_IDLE) begin idle++; p++; end
            ok = (p < sb.size()) && sc[p] && (sb[p] == XGMII_START) && (p % B == 0);
            chk(ok, "start_char", 64'(p), 64'(f));
            if (!ok) return;
            if (f > 0) chk(idle + 1 >= IFG, "ifg_gap", 64'(idle + 1), 64'(IFG));
            p++;
            bad = 0;
            for (int j = 1; j < PRE; j++) begin
                want = (j == PRE - 1) ? XGMII_SFD : XGMII_PRE;
                if (p >= sb.size() || sc[p] || sb[p] != want) bad++;
                p++;
            end
            chk(bad == 0, "preamble", 64'(bad), 64'(0));
            bad = 0;
            for (int j = 0; j < el[f]; j++) begin
                if (p >= sb.size() || sc[p] || sb[p] != ex[off + j]) bad++;
                p++;
            end
            off += el[f];
            chk(bad == 0, "payload", 64'(bad), 64'(0));
            ok = (p < sb.size()) && sc[p] && (sb[p] == XGMII_TERM);
            chk(ok, "terminate", 64'(p), 64'(f));
            p++;
        end
        bad = 0;
        while (p < sb.size()) begin
            if (!(sc[p] && sb[p] == XGMII_IDLE)) bad++;
            p++;
        end
        chk(bad == 0, "tail_idle", 64'(bad), 64'(0));
    endtask

    function automatic bit is_idle64(input logic [63:0] d, input logic [7:0] c);
        return (c == 8'hFF) && (d == {8{XGMII_IDLE}});
    endfunction

    function automatic bit is_sof64(input logic [63:0] d, input logic [7:0] c);
        return c[0] && (d[7:0] == XGMII_START);
    endfunction

    typedef struct {
        int          len;
        bit          empty_last;
        bit          stray;
        logic [63:0] t_txd;
        logic [7:0]  t_txc;
        int          idle_w;
    } vec_t;

    vec_t tab[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, n, j, fe_i, fd_after, nonidle;
        logic [CW-1:0] f0, a0;
        bit found;

        // Payload byte i = i; expected terminate word and idle words before the next start
        tab[0] = '{64, 1'b0, 1'b0, 64'h07070707070707FD, 8'hFF, 2};
        tab[1] = '{61, 1'b0, 1'b0, 64'h0707FD3C3B3A3938, 8'hE0, 3};
        tab[2] = '{60, 1'b0, 1'b0, 64'h070707FD3B3A3938, 8'hF0, 2};
        tab[3] = '{64, 1'b1, 1'b0, 64'h07070707070707FD, 8'hFF, 2};
        tab[4] = '{1,  1'b0, 1'b0, 64'h070707070707FD00, 8'hFE, 2};
        tab[5] = '{15, 1'b0, 1'b0, 64'hFD0E0D0C0B0A0908, 8'h80, 3};
        tab[6] = '{61, 1'b0, 1'b1, 64'h0707FD3C3B3A3938, 8'hE0, 3};

        rst = 1'b1;
        a_tdata = '0; a_tkeep = '0; a_tvalid = 1'b0; a_tlast = 1'b0;
        b_tdata = '0; b_tkeep = '0; b_tvalid = 1'b0; b_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(a_txd == {8{XGMII_IDLE}}, "rst_txd64", a_txd, {8{XGMII_IDLE}});
        chk(a_txc == 8'hFF, "rst_txc64", 64'(a_txc), 64'hFF);
        chk(a_tready == 1'b0, "rst_tready", 64'(a_tready), 64'(0));
        chk(a_fcnt == '0 && a_acnt == '0, "rst_counters", {a_fcnt, a_acnt}, 64'(0));
        chk(a_busy == 1'b0, "rst_busy", 64'(a_busy), 64'(0));
        chk(b_txd == {4{XGMII_IDLE}} && b_txc == 4'hF, "rst_txd32", {b_txc, b_txd}, {4'hF, 32'h07070707});
        tick();
        rst = 1'b0;
        tick();

        // Directed table, frames back to back, then a trailer so every entry has a following start
        clear_capture();
        f0 = a_fcnt;
        foreach (tab[i]) send(1'b0, tab[i].len, tab[i].empty_last, tab[i].stray, 1'b0, -1, 0, 1'b1);
        send(1'b0, 8, 1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
        wait_idle(1'b0);
        e = 0;
        for (int i = 0; i < aw_d.size(); i++) begin
            if (aw_c[i] != 8'h00 && !is_sof64(aw_d[i], aw_c[i]) && !is_idle64(aw_d[i], aw_c[i]) && e < 7) begin
                chk(aw_d[i] == tab[e].t_txd, "term_word", aw_d[i], tab[e].t_txd);
                chk(aw_c[i] == tab[e].t_txc, "term_ctl", 64'(aw_c[i]), 64'(tab[e].t_txc));
                n = 0;
                j = i + 1;
                while (j < aw_d.size() && is_idle64(aw_d[j], aw_c[j])) begin n++; j++; end
                chk(j < aw_d.size() && is_sof64(aw_d[j], aw_c[j]) && n == tab[e].idle_w,
                    "idle_words", 64'(n), 64'(tab[e].idle_w));
                e++;
            end
        end
        chk(e == 7, "term_count", 64'(e), 64'(7));
        chk(a_fcnt - f0 == CW'(8), "frame_cnt_table", 64'(a_fcnt - f0), 64'(8));
        parse_check(1'b0);

        // Randomized 64-bit traffic
        clear_capture();
        f0 = a_fcnt;
        for (int i = 0; i < 30; i++) begin
            int len;
            len = $urandom_range(1, 130);
            send(1'b0, len, (len % 8 == 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0,
                 1'b1, -1, 0, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(1'b0);
        parse_check(1'b0);
        chk(a_fcnt - f0 == CW'(30), "frame_cnt_rand64", 64'(a_fcnt - f0), 64'(30));

        // Underrun after three beats of a 64-byte frame
        clear_capture();
        f0 = a_fcnt;
        a0 = a_acnt;
        send(1'b0, 64, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
        wait_idle(1'b0);
        found = 1'b0;
        fe_i = 0;
        for (int i = 0; i < aw_d.size(); i++) begin
            if (!found && aw_d[i] == {8{XGMII_ERR}} && aw_c[i] == 8'hFF) begin found = 1'b1; fe_i = i; end
        end
        chk(found, "err_word", 64'(found), 64'(1));
        fd_after = 0;
        for (int i = fe_i; i < aw_d.size(); i++)
            for (int l = 0; l < 8; l++)
                if (aw_c[i][l] && aw_d[i][8*l +: 8] == XGMII_TERM) fd_after++;
        chk(fd_after == 0, "no_term_after_abort", 64'(fd_after), 64'(0));
        chk(a_acnt - a0 == CW'(1), "abort_cnt", 64'(a_acnt - a0), 64'(1));
        chk(a_fcnt == f0, "frame_cnt_abort", 64'(a_fcnt), 64'(f0));

        // 32-bit preamble and 46-byte frame ending in lane 2
        clear_capture();
        send(1'b1, 46, 1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
        wait_idle(1'b1);
        found = 1'b0;
        for (int i = 0; i + 1 < bw_d.size(); i++) begin
            if (!found && bw_c[i][0] && bw_d[i][7:0] == XGMII_START) begin
                found = 1'b1;
                chk(bw_d[i] == 32'h555555FB && bw_c[i] == 4'b0001, "pre32_w0",
                    {bw_c[i], bw_d[i]}, {4'b0001, 32'h555555FB});
                chk(bw_d[i+1] == 32'hD5555555 && bw_c[i+1] == 4'b0000, "pre32_w1",
                    {bw_c[i+1], bw_d[i+1]}, {4'b0000, 32'hD5555555});
            end
        end
        chk(found, "pre32_found", 64'(found), 64'(1));
        found = 1'b0;
        for (int i = 0; i < bw_d.size(); i++) begin
            if (bw_c[i] != 4'h0 && bw_c[i] != 4'hF && !(bw_c[i][0] && bw_d[i][7:0] == XGMII_START)) begin
                found = 1'b1;
                chk(bw_d[i] == 32'h07FD2D2C && bw_c[i] == 4'b1100, "term32",
                    {bw_c[i], bw_d[i]}, {4'b1100, 32'h07FD2D2C});
            end
        end
        chk(found, "term32_found", 64'(found), 64'(1));
        parse_check(1'b1);

        // Randomized 32-bit traffic
        clear_capture();
        f0 = b_fcnt;
        for (int i = 0; i < 20; i++) begin
            int len;
            len = $urandom_range(1, 90);
            send(1'b1, len, (len % 4 == 0) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0,
                 1'b1, -1, 0, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(1'b1);
        parse_check(1'b1);
        chk(b_fcnt - f0 == CW'(20), "frame_cnt_rand32", 64'(b_fcnt - f0), 64'(20));

        // Reset while a frame is in DATA
        a_tdata = 64'h1122334455667788; a_tkeep = 8'hFF; a_tlast = 1'b0; a_tvalid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = a_tready;
            tick();
        end
        chk(found, "reach_data", 64'(found), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(a_txd == {8{XGMII_IDLE}} && a_txc == 8'hFF, "midrst_word", a_txd, {8{XGMII_IDLE}});
        chk(a_tready == 1'b0 && a_busy == 1'b0, "midrst_ready_busy", 64'({a_tready, a_busy}), 64'(0));
        chk(a_fcnt == '0 && a_acnt == '0, "midrst_counters", {a_fcnt, a_acnt}, 64'(0));
        tick();
        rst = 1'b0;
        a_tvalid = 1'b0;
        nonidle = 0;
        repeat (5) begin
            @(negedge clk);
            if (!is_idle64(a_txd, a_txc)) nonidle++;
        end
        chk(nonidle == 0, "post_rst_idle", 64'(nonidle), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
